// File: rtl/tx_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// tx_pkt_scheduler
// Chooses the next packet for the USB endpoint TX encoder and drives its
// packet code and start strobe. Handshakes (ACK/NAK/STALL) take priority
// over data. The block also owns the DATA0/DATA1 toggle, holds off new
// packets for an inter-packet gap, and times out a missing host ACK.
//
// Ports
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   hs_req       : level, handshake send request; hs_type selects the code
//   data_req     : level, data packet send request
//   toggle_load  : pulse, loads toggle from toggle_val (in any state)
//   tx_done      : pulse from the encoder, current packet fully sent
//   rx_ack       : pulse, host ACK received
//   tx_start     : one-cycle start strobe to the encoder
//   tx_packet    : 0=IDLE 1=DATA0 2=DATA1 3=ACK 4=NAK 5=STALL
//   hs_gnt       : one-cycle grant to the handshake requester
//   data_gnt     : one-cycle grant to the data requester
//   data_retry   : one-cycle pulse, ACK timed out and data must be resent
//   toggle       : current data toggle (0 = next data packet is DATA0)
//   busy         : high whenever the scheduler is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module tx_pkt_scheduler #(
  parameter int IPG_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic       toggle_load,
  input  logic       toggle_val,
  input  logic       tx_done,
  input  logic       rx_ack,
  output logic       tx_start,
  output logic [2:0] tx_packet,
  output logic       hs_gnt,
  output logic       data_gnt,
  output logic       data_retry,
  output logic       toggle,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_ACK  = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [2:0] PKT_IDLE  = 3'd0;
  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  // With no gap configured, a finished exchange returns straight to IDLE.
  localparam state_t AFTER_PKT = (IPG_CYCLES == 0) ? IDLE : GAP;

  // Reserved handshake type 3 is sent as STALL.
  function automatic logic [2:0] hs_code(input logic [1:0] t);
    case (t)
      2'd0:    hs_code = PKT_ACK;
      2'd1:    hs_code = PKT_NAK;
      default: hs_code = PKT_STALL;
    endcase
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       pkt_nx;
  logic             start_nx, hs_gnt_nx, data_gnt_nx, retry_nx, toggle_nx;
  logic             is_data;

  assign is_data = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pkt_nx      = tx_packet;
    start_nx    = 1'b0;
    hs_gnt_nx   = 1'b0;
    data_gnt_nx = 1'b0;
    retry_nx    = 1'b0;
    toggle_nx   = toggle;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (hs_req) begin
          hs_gnt_nx = 1'b1;
          start_nx  = 1'b1;
          pkt_nx    = hs_code(hs_type);
          state_nx  = WAIT_DONE;
        end else if (data_req) begin
          data_gnt_nx = 1'b1;
          start_nx    = 1'b1;
          pkt_nx      = toggle ? PKT_DATA1 : PKT_DATA0;
          state_nx    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
          pkt_nx   = PKT_IDLE;
          cnt_nx   = '0;
          state_nx = is_data ? WAIT_ACK : AFTER_PKT;
        end
      end

      WAIT_ACK: begin
        // An ACK arriving on the timeout cycle still counts as an ACK.
        if (rx_ack) begin
          toggle_nx = ~toggle;
          cnt_nx    = '0;
          state_nx  = AFTER_PKT;
        end else if (cnt == ACK_LAST) begin
          retry_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = AFTER_PKT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      GAP: begin
        if (cnt == IPG_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        pkt_nx   = PKT_IDLE;
      end
    endcase

    // An explicit load overrides the ACK flip.
    if (toggle_load) toggle_nx = toggle_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_packet  <= PKT_IDLE;
      tx_start   <= 1'b0;
      hs_gnt     <= 1'b0;
      data_gnt   <= 1'b0;
      data_retry <= 1'b0;
      toggle     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      tx_packet  <= pkt_nx;
      tx_start   <= start_nx;
      hs_gnt     <= hs_gnt_nx;
      data_gnt   <= data_gnt_nx;
      data_retry <= retry_nx;
      toggle     <= toggle_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_pkt_scheduler
// Self-checking bench for tx_pkt_scheduler (IPG_CYCLES=2, ACK_TIMEOUT=16).
// Expected packets are queued when a request is driven and compared when
// the DUT raises tx_start; control outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_tx_pkt_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_req;
  logic [1:0] hs_type;
  logic       data_req;
  logic       toggle_load;
  logic       toggle_val;
  logic       tx_done;
  logic       rx_ack;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic       hs_gnt;
  logic       data_gnt;
  logic       data_retry;
  logic       toggle;
  logic       busy;

  typedef struct {
    logic [2:0] pkt;
    logic       hs;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  tx_pkt_scheduler #(
    .IPG_CYCLES (2),
    .ACK_TIMEOUT(16),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hs_req     (hs_req),
    .hs_type    (hs_type),
    .data_req   (data_req),
    .toggle_load(toggle_load),
    .toggle_val (toggle_val),
    .tx_done    (tx_done),
    .rx_ack     (rx_ack),
    .tx_start   (tx_start),
    .tx_packet  (tx_packet),
    .hs_gnt     (hs_gnt),
    .data_gnt   (data_gnt),
    .data_retry (data_retry),
    .toggle     (toggle),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One cycle: advance past the rising edge, then drive/sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (tx_start) break;
    end
    chk("start_seen", tx_start, 1);
  endtask

  task automatic push_exp(input logic [2:0] p, input logic h);
    exp_t e;
    e.pkt = p;
    e.hs  = h;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every start strobe must match the oldest queued packet.
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_packet", tx_packet, e.pkt);
        chk("sb_hs_gnt", hs_gnt, e.hs);
        chk("sb_data_gnt", data_gnt, !e.hs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int retries;

    rst = 1'b1; hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0;
    toggle_load = 1'b0; toggle_val = 1'b0; tx_done = 1'b0; rx_ack = 1'b0;
    repeat (2) step();
    chk("rst_packet", tx_packet, 0);
    chk("rst_toggle", toggle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_gnt", hs_gnt, 0);
    chk("rst_retry", data_retry, 0);
    rst = 1'b0;
    step();

    // Handshake ACK, then gap timing
    hs_req = 1'b1; hs_type = 2'd0;
    push_exp(3'd3, 1'b1);
    step();
    chk("hs_latency_gnt", hs_gnt, 1);
    chk("hs_latency_start", tx_start, 1);
    hs_req = 1'b0;
    step(); step();
    chk("hs_pkt_held", tx_packet, 3);
    chk("hs_no_regnt", hs_gnt, 0);
    chk("hs_busy", busy, 1);
    pulse_done();
    chk("hs_pkt_clear", tx_packet, 0);
    chk("gap_busy0", busy, 1);
    step();
    chk("gap_busy1", busy, 1);
    step();
    chk("busy_drop", busy, 0);

    // Data DATA0 with ACK, then DATA1
    data_req = 1'b1;
    push_exp(3'd1, 1'b0);
    wait_start(4);
    data_req = 1'b0;
    step();
    pulse_done();
    chk("data_pkt_clear", tx_packet, 0);
    repeat (4) step();
    pulse_ack();
    chk("ack_toggle1", toggle, 1);
    chk("ack_no_retry", data_retry, 0);
    repeat (2) step();
    chk("ack_gap_idle", busy, 0);
    data_req = 1'b1;
    push_exp(3'd2, 1'b0);
    wait_start(4);
    data_req = 1'b0;
    pulse_done();
    step();
    pulse_ack();
    chk("ack_toggle0", toggle, 0);
    repeat (2) step();

    // Simultaneous requests: NAK wins, data follows after the gap
    hs_req = 1'b1; hs_type = 2'd1; data_req = 1'b1;
    push_exp(3'd4, 1'b1);
    push_exp(3'd1, 1'b0);
    wait_start(4);
    hs_req = 1'b0;
    chk("arb_hs_first", hs_gnt, 1);
    chk("arb_data_wait", data_gnt, 0);
    step();
    chk("arb_no_gnt_busy", data_gnt, 0);
    pulse_done();
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (tx_start) break;
    end
    chk("arb_gap_latency", lat, 3);
    chk("arb_data_gnt", data_gnt, 1);
    data_req = 1'b0;
    pulse_done();
    step();
    pulse_ack();
    chk("arb_toggle", toggle, 1);
    repeat (2) step();

    // Toggle load in IDLE; stray rx_ack/tx_done ignored
    toggle_load = 1'b1; toggle_val = 1'b0;
    step();
    toggle_load = 1'b0;
    chk("load_idle", toggle, 0);
    rx_ack = 1'b1; tx_done = 1'b1;
    step();
    rx_ack = 1'b0; tx_done = 1'b0;
    chk("stray_toggle", toggle, 0);
    chk("stray_busy", busy, 0);
    chk("stray_start", tx_start, 0);

    // ACK timeout
    data_req = 1'b1;
    push_exp(3'd1, 1'b0);
    wait_start(4);
    data_req = 1'b0;
    pulse_done();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (data_retry) break;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_toggle", toggle, 0);
    step();
    chk("retry_single", data_retry, 0);
    step();

    // Resend uses DATA0; load beats the ACK flip
    data_req = 1'b1;
    push_exp(3'd1, 1'b0);
    wait_start(4);
    data_req = 1'b0;
    pulse_done();
    step();
    toggle_load = 1'b1; toggle_val = 1'b0; rx_ack = 1'b1;
    step();
    toggle_load = 1'b0; rx_ack = 1'b0;
    chk("load_beats_ack", toggle, 0);
    chk("load_no_retry", data_retry, 0);
    repeat (2) step();

    // Reset during DATA1 WAIT_DONE
    toggle_load = 1'b1; toggle_val = 1'b1;
    step();
    toggle_load = 1'b0;
    chk("load_one", toggle, 1);
    data_req = 1'b1;
    push_exp(3'd2, 1'b0);
    wait_start(4);
    data_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_packet", tx_packet, 0);
    chk("midrst_toggle", toggle, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_start", tx_start, 0);
    retries = 0;
    repeat (20) begin
      step();
      if (data_retry) retries++;
    end
    chk("midrst_no_retry", retries, 0);
    chk("midrst_idle", busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
